// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM input capture: high time, period and stuck-input detection
module pwm_capture #(
    parameter int CW      = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          PwmIn,
    output logic [CW-1:0] HighCount,
    output logic [CW-1:0] PeriodCount,
    output logic          Valid,
    output logic          Stuck,
    output logic          StuckLevel
);

    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE         = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STUCK = 2'd2
    } state_t;

    state_t        state;
    logic          s1;
    logic          s2;
    logic          s3;
    logic [CW-1:0] per_cnt;
    logic [CW-1:0] hi_cnt;
    logic          rise;
    logic          timeout;

    // Two-flop synchronizer for the asynchronous input plus one delay flop for edge detection
    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= PwmIn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // A rise in the same cycle wins over the timeout, so only a rise-free cycle can time out
    assign timeout = (per_cnt == TIMEOUT_CNT) && !rise;

    // Measurement FSM: counts rise-to-rise cycles and high cycles, publishes on each rise
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            per_cnt     <= '0;
            hi_cnt      <= '0;
            HighCount   <= '0;
            PeriodCount <= '0;
            Valid       <= 1'b0;
            Stuck       <= 1'b0;
            StuckLevel  <= 1'b0;
        end else begin
            Valid <= 1'b0;
            case (state)
                IDLE: begin
                    // First rise only starts a period; the partial one before it is not published
                    if (rise) begin
                        per_cnt <= ONE;
                        hi_cnt  <= ONE;
                        state   <= RUN;
                    end else if (timeout) begin
                        state      <= STUCK;
                        Stuck      <= 1'b1;
                        StuckLevel <= s2;
                    end else begin
                        per_cnt <= per_cnt + ONE;
                    end
                end
                RUN: begin
                    if (rise) begin
                        HighCount   <= hi_cnt;
                        PeriodCount <= per_cnt;
                        Valid       <= 1'b1;
                        per_cnt     <= ONE;
                        hi_cnt      <= ONE;
                    end else if (timeout) begin
                        state      <= STUCK;
                        Stuck      <= 1'b1;
                        StuckLevel <= s2;
                    end else begin
                        per_cnt <= per_cnt + ONE;
                        if (s2) begin
                            hi_cnt <= hi_cnt + ONE;
                        end
                    end
                end
                STUCK: begin
                    // Counters hold at TIMEOUT while stuck so they can never wrap
                    if (rise) begin
                        Stuck   <= 1'b0;
                        per_cnt <= ONE;
                        hi_cnt  <= ONE;
                        state   <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;

    localparam int TIMEOUT_A = 1023;
    localparam int TIMEOUT_B = 2;

    logic        Clock;
    logic        Reset;
    logic        PwmIn;
    logic [15:0] hc_a;
    logic [15:0] pc_a;
    logic        valid_a;
    logic        stuck_a;
    logic        lvl_a;
    logic [15:0] hc_b;
    logic [15:0] pc_b;
    logic        valid_b;
    logic        stuck_b;
    logic        lvl_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int h;
        int p;
        int c;
    } exp_t;

    exp_t q[$];
    exp_t e_a;
    int   prev_h;
    int   prev_p;
    bit   have_prev;
    bit   chk_b;
    int   b_valids;

    pwm_capture #(.CW(16), .TIMEOUT(TIMEOUT_A)) dut_a (
        .Clock       (Clock),
        .Reset       (Reset),
        .PwmIn       (PwmIn),
        .HighCount   (hc_a),
        .PeriodCount (pc_a),
        .Valid       (valid_a),
        .Stuck       (stuck_a),
        .StuckLevel  (lvl_a)
    );

    pwm_capture #(.CW(16), .TIMEOUT(TIMEOUT_B)) dut_b (
        .Clock       (Clock),
        .Reset       (Reset),
        .PwmIn       (PwmIn),
        .HighCount   (hc_b),
        .PeriodCount (pc_b),
        .Valid       (valid_b),
        .Stuck       (stuck_b),
        .StuckLevel  (lvl_b)
    );

    initial begin
        Clock = 1'b0;
        forever #10 Clock = ~Clock;
    end

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Each published period must match the oldest completed segment, at the predicted cycle
    always @(negedge Clock) begin
        if (valid_a) begin
            chk("valid_expected", q.size() > 0, 1'b1);
            if (q.size() > 0) begin
                e_a = q.pop_front();
                chk("high_count", hc_a, e_a.h);
                chk("period_count", pc_a, e_a.p);
                chk("valid_cycle", cyc, e_a.c);
            end
        end
    end

    always @(negedge Clock) begin
        if (chk_b) begin
            chk("b_stuck", stuck_b, 1'b0);
            if (valid_b) begin
                b_valids++;
                chk("b_high", hc_b, 1);
                chk("b_period", pc_b, 2);
            end
        end
    end

    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            PwmIn = lvl;
            @(posedge Clock);
            #1;
        end
    endtask

    // A rise now completes the previous segment; its Valid lands three edges later
    task automatic push_prev();
        if (have_prev) q.push_back('{prev_h, prev_p, cyc + 3});
    endtask

    task automatic seg(input int h, input int p);
        push_prev();
        prev_h    = h;
        prev_p    = p;
        have_prev = 1'b1;
        hold(1'b1, h);
        hold(1'b0, p - h);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset     = 1'b0;
        have_prev = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_hc"}, hc_a, 0);
        chk({tag, "_pc"}, pc_a, 0);
        chk({tag, "_valid"}, valid_a, 0);
        chk({tag, "_stuck"}, stuck_a, 0);
        chk({tag, "_lvl"}, lvl_a, 0);
    endtask

    initial begin
        int p;
        int h;
        Reset     = 1'b0;
        PwmIn     = 1'b0;
        have_prev = 1'b0;
        chk_b     = 1'b0;
        b_valids  = 0;
        @(posedge Clock);
        #1;
        do_reset();
        check_zero("reset");
        chk("reset_b_hc", hc_b, 0);
        chk("reset_b_stuck", stuck_b, 0);

        // Generator loop-back at duty 128, then duty 1 and 255
        for (int i = 0; i < 5; i++) seg(128, 256);
        chk("loop_stuck", stuck_a, 0);
        for (int i = 0; i < 3; i++) seg(1, 256);
        for (int i = 0; i < 3; i++) seg(255, 256);

        // Random high/period pairs
        for (int i = 0; i < 20; i++) begin
            p = $urandom_range(800, 2);
            h = $urandom_range(p - 1, 1);
            seg(h, p);
        end

        // Input stuck high after duty 64
        for (int i = 0; i < 4; i++) seg(64, 256);
        push_prev();
        have_prev = 1'b0;
        hold(1'b1, TIMEOUT_A + 2);
        chk("hi_stuck_early", stuck_a, 0);
        hold(1'b1, 1);
        chk("hi_stuck", stuck_a, 1);
        chk("hi_stuck_lvl", lvl_a, 1);
        chk("hi_retain_hc", hc_a, 64);
        chk("hi_retain_pc", pc_a, 256);

        // Input low from reset, then a 10/20 waveform
        hold(1'b0, 5);
        do_reset();
        check_zero("reset2");
        hold(1'b0, TIMEOUT_A);
        chk("lo_stuck_early", stuck_a, 0);
        hold(1'b0, 1);
        chk("lo_stuck", stuck_a, 1);
        chk("lo_stuck_lvl", lvl_a, 0);
        chk("lo_hc", hc_a, 0);
        seg(10, 20);
        chk("lo_unstuck", stuck_a, 0);
        seg(10, 20);
        seg(10, 20);

        // Reset pulse during the low phase of a duty 200 period
        for (int i = 0; i < 3; i++) seg(200, 256);
        push_prev();
        have_prev = 1'b0;
        hold(1'b1, 200);
        hold(1'b0, 20);
        do_reset();
        check_zero("reset3");
        hold(1'b0, 10);
        for (int i = 0; i < 3; i++) seg(200, 256);

        // Minimum period; the TIMEOUT=2 instance sees every rise on its timeout cycle
        for (int i = 0; i < 4; i++) seg(1, 2);
        chk_b = 1'b1;
        for (int i = 0; i < 6; i++) seg(1, 2);
        chk_b = 1'b0;
        chk("b_valid_count", b_valids, 6);

        // Close the last segment and drain
        push_prev();
        have_prev = 1'b0;
        hold(1'b1, 3);
        hold(1'b0, 5);
        chk("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart of the 8-bit PWM generator: samples an asynchronous PWM input and measures, per period, the number of Clock cycles the input is high and the number of cycles between consecutive rising edges. Used for loop-back checking of the generator on the FPGA and for decoding external PWM sources such as servo or fan tach lines. It also flags a stuck input, covering the 0% and 100% cases, where no edges occur.

## Interface
- CW, 16, width of the cycle counters and of the measurement outputs
- TIMEOUT, 1023, cycles without a rising edge before Stuck asserts; legal range 2..2^CW-1
- Clock  input  1  system clock (50 MHz); all logic on posedge
- Reset  input  1  synchronous, active-high reset
- PwmIn  input  1  asynchronous PWM input
- HighCount  output  CW  high cycles in the last complete period
- PeriodCount  output  CW  cycles from rising edge to rising edge, last complete period
- Valid  output  1  one-cycle strobe; HighCount and PeriodCount updated this cycle
- Stuck  output  1  no rising edge for TIMEOUT cycles
- StuckLevel  output  1  synchronized input level when Stuck asserted

## Operation
- Input conditioning: two-flop synchronizer s1 -> s2, plus delay flop s3. rise = s2 & ~s3. The level is s2.
- Internal counters: per_cnt and hi_cnt, each CW bits.
- States:
  - IDLE: entered on reset; waiting for the first rising edge.
  - RUN: measuring a period.
  - STUCK: timed out.
- IDLE:
  - per_cnt increments every cycle.
  - On rise: per_cnt=1, hi_cnt=1, go to RUN. No publish, because the period is partial.
- RUN, on a cycle without rise:
  - per_cnt increments.
  - hi_cnt increments if s2=1.
- RUN, on rise:
  - HighCount<=hi_cnt, PeriodCount<=per_cnt, Valid<=1.
  - Then per_cnt=1, hi_cnt=1; stay in RUN.
- Timeout:
  - Condition: in IDLE or RUN, per_cnt==TIMEOUT and no rise this cycle.
  - Action: go to STUCK, Stuck<=1, StuckLevel<=s2.
  - HighCount and PeriodCount keep their last values; no Valid.
- STUCK, on rise:
  - Stuck<=0, per_cnt=1, hi_cnt=1, go to RUN.
  - No publish. The next full period publishes normally.
- Counter width:
  - Counters never exceed TIMEOUT, so they cannot wrap.
  - Saturating logic is not needed; TIMEOUT ≤ 2^CW-1 is a parameter rule.
- Simultaneous events: rise takes priority over timeout in the same cycle.
- Reset mid-operation clears all state. Behaviour after reset is identical to power-up.
- Pulse width: single-cycle high pulses, as seen after synchronization, are counted and are not filtered.
- Generator compatibility, period 256 cycles:
  - Duty=d, 1..255: HighCount=d, PeriodCount=256.
  - Duty=0: Stuck=1, StuckLevel=0.

## Timing
- Reset values:
  - HighCount=0, PeriodCount=0, Valid=0, Stuck=0, StuckLevel=0.
  - State=IDLE, s1=s2=s3=0.
- Latency: Valid asserts on the 3rd Clock edge after the first edge that samples PwmIn=1 at a rising edge (synchronizer 2 plus FSM 1).
- Measurements are latency-neutral: the same pipeline delay applies to both edges of a period.
- Valid is high for exactly one cycle per completed period. Outputs are registered and stable until the next Valid, Reset, or timeout.
- Stuck:
  - Asserts on the cycle after per_cnt reaches TIMEOUT.
  - Deasserts on the cycle after the FSM sees rise.
- Throughput: one measurement per input period. The minimum measurable period is 2 cycles (PeriodCount=2).

## Test plan
- Generator loop-back, Duty=128, 5 periods -> first Valid after the 2nd rising edge; then HighCount=128, PeriodCount=256 with Valid exactly every 256 cycles; Stuck=0.
- Duty=1 then Duty=255 (switch at a period boundary) -> HighCount=1, PeriodCount=256; then HighCount=255, PeriodCount=256. No period reports an intermediate value.
- PwmIn held low from reset, TIMEOUT=1023 -> Stuck=1, StuckLevel=0 around cycle 1024 after reset; Valid never asserts. Later apply a 10-high/20-period waveform -> Stuck=0 at the first rise; first Valid one period later with HighCount=10, PeriodCount=20.
- PwmIn held high after several Duty=64 periods -> last HighCount=64 retained; Stuck=1, StuckLevel=1 after TIMEOUT cycles without a rise.
- Reset pulsed for 1 cycle mid-period during Duty=200 -> all outputs 0 the next cycle; the first Valid comes only after the second post-reset rising edge, with HighCount=200, PeriodCount=256.
- Boundary waveform, 1 cycle high / 1 cycle low -> HighCount=1, PeriodCount=2, Valid every 2nd cycle. With TIMEOUT=2, a rise landing exactly on the timeout cycle -> Stuck stays 0.
